// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART RX controller slice.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Bit positions of the error flags within the 3-bit error field
    localparam int RX_ERR_FRAME  = 0;
    localparam int RX_ERR_PARITY = 1;
    localparam int RX_ERR_START  = 2;

    // FIFO entry: {start_err, parity_err, frame_err, data[7:0]}
    localparam int RX_ENTRY_W    = 11;
    localparam int RX_DATA_W     = 8;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        CAPT = 2'd1,
        HELD = 2'd2
    } rx_capt_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_controller_if
// Brief    : RX data read bus between the APB register file and the controller.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_controller_if;

    logic       rd_req;
    logic [7:0] rd_data;
    logic [2:0] rd_err;
    logic       rd_valid;

    modport master (output rd_req, input  rd_data, input  rd_err, input  rd_valid);
    modport slave  (input  rd_req, output rd_data, output rd_err, output rd_valid);

endinterface : uart_rx_controller_if
`default_nettype wire

// File: rtl/rx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rx_sync_fifo
// Brief    : Synchronous FIFO with flush; gates push/pop and reports acceptance.
// Revision : 1.0 - initial release
// ============================================================================
module rx_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int WIDTH = 11
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic             i_pop,
    input  wire logic             i_flush,
    output logic [WIDTH-1:0]      o_rdata,
    output logic                  o_push_acc,
    output logic                  o_pop_acc,
    output logic [AW:0]           o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic w_pop_acc;
    logic w_push_acc;

    // Flush wins; a push into a full FIFO is only taken alongside a real pop
    assign w_pop_acc  = i_pop  && !o_empty && !i_flush;
    assign w_push_acc = i_push && (!o_full || w_pop_acc) && !i_flush;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == c_full_count);
    assign o_count    = r_count;
    assign o_rdata    = r_mem[r_rptr];
    assign o_push_acc = w_push_acc;
    assign o_pop_acc  = w_pop_acc;

    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : rx_sync_fifo
`default_nettype wire

// File: rtl/uart_rx_controller.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_controller
// Brief    : Frame capture, RX FIFO, sticky errors, RX timeout and IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int TOUT_W = 16
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire logic                  rx_en,
    input  wire logic [RX_ENTRY_W-1:0] eng_data,
    input  wire logic                  eng_valid,
    uart_rx_controller_if.slave        rd_bus,
    input  wire logic                  flush,
    input  wire logic [3:0]            err_clr,
    input  wire logic [AW:0]           cfg_thresh,
    input  wire logic [TOUT_W-1:0]     cfg_tout,
    input  wire logic [2:0]            cfg_ie,
    output logic [AW:0]                fifo_count,
    output logic                       empty,
    output logic                       full,
    output logic [3:0]                 err_sticky,
    output logic                       tout_flag,
    output logic                       irq
);

    rx_capt_state_t        r_state;
    logic [RX_ENTRY_W-1:0] w_fifo_rdata;
    logic                  w_push;
    logic                  w_push_acc;
    logic                  w_pop_acc;
    logic                  w_overrun;
    logic [3:0]            w_err_set;
    logic [7:0]            r_rd_data;
    logic [2:0]            r_rd_err;
    logic                  r_rd_valid;
    logic [3:0]            r_err;
    logic [TOUT_W-1:0]     r_tout_cnt;
    logic                  r_tout_flag;
    logic                  r_irq;
    logic                  w_level_hit;

    // One push attempt per frame: eng_valid stays high until the next start bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARM;
        end else begin
            case (r_state)
                ARM:     if (eng_valid)  r_state <= CAPT;
                CAPT:                    r_state <= HELD;
                HELD:    if (!eng_valid) r_state <= ARM;
                default:                 r_state <= ARM;
            endcase
        end
    end

    assign w_push = (r_state == CAPT) && rx_en;

    rx_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (RX_ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_push     (w_push),
        .i_wdata    (eng_data),
        .i_pop      (rd_bus.rd_req),
        .i_flush    (flush),
        .o_rdata    (w_fifo_rdata),
        .o_push_acc (w_push_acc),
        .o_pop_acc  (w_pop_acc),
        .o_count    (fifo_count),
        .o_full     (full),
        .o_empty    (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_err   <= '0;
        end else begin
            r_rd_valid <= w_pop_acc;
            if (w_pop_acc) begin
                r_rd_data <= w_fifo_rdata[RX_DATA_W-1:0];
                r_rd_err  <= w_fifo_rdata[RX_ENTRY_W-1:RX_DATA_W];
            end
        end
    end

    assign rd_bus.rd_valid = r_rd_valid;
    assign rd_bus.rd_data  = r_rd_data;
    assign rd_bus.rd_err   = r_rd_err;

    assign w_overrun = w_push && !w_push_acc && !flush;
    assign w_err_set = {w_overrun,
                        w_push & eng_data[RX_DATA_W + RX_ERR_START],
                        w_push & eng_data[RX_DATA_W + RX_ERR_PARITY],
                        w_push & eng_data[RX_DATA_W + RX_ERR_FRAME]};

    // New events take precedence over a same-cycle write-1-clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= '0;
        end else begin
            r_err <= (r_err & ~err_clr) | w_err_set;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tout_cnt  <= '0;
            r_tout_flag <= 1'b0;
        end else begin
            if (flush || w_push_acc || w_pop_acc || empty) begin
                r_tout_cnt <= '0;
            end else if (cfg_tout != '0) begin
                r_tout_cnt <= (r_tout_cnt < cfg_tout) ? r_tout_cnt + 1'b1 : cfg_tout;
            end
            if (flush || w_pop_acc || empty) begin
                r_tout_flag <= 1'b0;
            end else if ((cfg_tout != '0) && (r_tout_cnt == cfg_tout)) begin
                r_tout_flag <= 1'b1;
            end
        end
    end

    assign w_level_hit = (cfg_thresh != '0) && (fifo_count >= cfg_thresh);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (cfg_ie[0] && w_level_hit)
                   | (cfg_ie[1] && r_tout_flag)
                   | (cfg_ie[2] && (|r_err));
        end
    end

    assign err_sticky = r_err;
    assign tout_flag  = r_tout_flag;
    assign irq        = r_irq;

endmodule : uart_rx_controller
`default_nettype wire
